dac_sample_conditioner: RTL and testbench

//   Conditions I/Q (sine/cosine) samples from the NCO/CORDIC stage into the 14-bit words that

---
 rtl/dac_pkg.sv | 22 ++
 rtl/dac_sample_conditioner_if.sv | 34 +++
 rtl/dac_scale_sat.sv | 85 ++++++++
 rtl/dac_sample_conditioner.sv | 151 +++++++++++++++
 tb/tb_dac_sample_conditioner.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dac_pkg.sv
// ---------------------------------------------------------------------------
// dac_pkg
//   Shared definitions for the DAC sample conditioner.
//   - dac_state_t : envelope FSM states (IDLE/RAMP_UP/RUN/RAMP_DOWN)
//   - midscale()  : DAC word that represents zero amplitude, as a function of
//                   the output width and the output number format
// ---------------------------------------------------------------------------
package dac_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RUN       = 2'd2,
        RAMP_DOWN = 2'd3
    } dac_state_t;

    // Offset-binary zero sits at half scale; two's complement zero is 0.
    function automatic int midscale(input int out_w, input bit offset_bin);
        return offset_bin ? (1 << (out_w - 1)) : 0;
    endfunction

endpackage

// File: rtl/dac_sample_conditioner_if.sv
// ---------------------------------------------------------------------------
// dac_sample_conditioner_if
//   Sample/control bundle between the NCO/CORDIC side and the conditioner.
//   master : sample source / controller (drives samples, gain, enable, sat_clr)
//   slave  : dac_sample_conditioner (drives DAC words, out_valid, sat_flag,
//            state_o)
// ---------------------------------------------------------------------------
interface dac_sample_conditioner_if #(
    parameter int IN_W   = 16,
    parameter int OUT_W  = 14,
    parameter int GAIN_W = 16
);
    logic                     in_valid;
    logic signed [IN_W-1:0]   in_sin;
    logic signed [IN_W-1:0]   in_cos;
    logic        [GAIN_W-1:0] gain;
    logic                     enable;
    logic                     sat_clr;
    logic        [OUT_W-1:0]  data1;
    logic        [OUT_W-1:0]  data2;
    logic                     out_valid;
    logic                     sat_flag;
    logic        [1:0]        state_o;

    modport master (
        output in_valid, in_sin, in_cos, gain, enable, sat_clr,
        input  data1, data2, out_valid, sat_flag, state_o
    );

    modport slave (
        input  in_valid, in_sin, in_cos, gain, enable, sat_clr,
        output data1, data2, out_valid, sat_flag, state_o
    );
endinterface

// File: rtl/dac_scale_sat.sv
// ---------------------------------------------------------------------------
// dac_scale_sat
//   One channel of the conditioning datapath:
//     S2: p = sample * env (env treated as unsigned Q1.15)
//     S3: round half up, saturate to the signed DAC range, apply output format
//   Ports:
//     clk, rst   clock and asynchronous active-high reset
//     s2_load    S1 holds a valid sample: capture the product
//     s3_load    S2 holds a valid product: update the DAC word
//     sample     S1 sample register (signed)
//     env        envelope value that belongs to the S1 sample
//     data       registered DAC word (resets to midscale)
//     sat        S3 result is being clipped (valid while s3_load is high)
// ---------------------------------------------------------------------------
module dac_scale_sat
    import dac_pkg::*;
#(
    parameter int IN_W       = 16,
    parameter int OUT_W      = 14,
    parameter int GAIN_W     = 16,
    parameter int OFFSET_BIN = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s2_load,
    input  logic                     s3_load,
    input  logic signed [IN_W-1:0]   sample,
    input  logic        [GAIN_W-1:0] env,
    output logic        [OUT_W-1:0]  data,
    output logic                     sat
);

    localparam int P_W = IN_W + GAIN_W + 1;
    localparam int SH  = 15 + IN_W - OUT_W;

    localparam logic        [OUT_W-1:0] MIDSCALE = OUT_W'(midscale(OUT_W, OFFSET_BIN != 0));
    localparam logic signed [P_W:0]     HALF     = (P_W+1)'(1) <<< (SH - 1);
    localparam logic signed [P_W:0]     SAT_MAX  = (P_W+1)'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [P_W:0]     SAT_MIN  = (P_W+1)'(-(1 << (OUT_W - 1)));
    localparam logic        [OUT_W-1:0] FMT_MASK = (OFFSET_BIN != 0) ? {1'b1, {(OUT_W-1){1'b0}}} : '0;

    logic signed [P_W-1:0] prod;
    logic signed [P_W:0]   rounded;
    logic signed [P_W:0]   shifted;
    logic        [OUT_W-1:0] clipped;

    // S2: env gets a zero sign bit so the multiply stays signed while the
    // gain keeps its full unsigned range up to ~2.0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod <= '0;
        end else if (s2_load) begin
            prod <= P_W'(sample) * P_W'($signed({1'b0, env}));
        end
    end

    // S3 arithmetic: one guard bit above the product keeps the rounding add
    // from wrapping; the arithmetic shift gives floor, so adding half first
    // rounds half up for both signs.
    always_comb begin
        rounded = (P_W+1)'(prod) + HALF;
        shifted = rounded >>> SH;
        clipped = shifted[OUT_W-1:0];
        sat     = 1'b0;
        if (shifted > SAT_MAX) begin
            clipped = SAT_MAX[OUT_W-1:0];
            sat     = 1'b1;
        end else if (shifted < SAT_MIN) begin
            clipped = SAT_MIN[OUT_W-1:0];
            sat     = 1'b1;
        end
    end

    // S3 register: the DAC word only moves when a sample reaches it and is
    // held between samples; offset binary is two's complement with the MSB
    // flipped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= MIDSCALE;
        end else if (s3_load) begin
            data <= clipped ^ FMT_MASK;
        end
    end

endmodule

// File: rtl/dac_sample_conditioner.sv
// ---------------------------------------------------------------------------
// dac_sample_conditioner
//   Turns I/Q samples into DAC words with a ramped amplitude envelope for
//   click-free enable/disable, rounding, saturation and output formatting.
//   Latency is 3 clocks, one sample pair per clock maximum.
//   Ports:
//     sys_clk  sole clock, rising edge
//     rst      asynchronous active-high reset
//     bus      dac_sample_conditioner_if.slave:
//                in_valid/in_sin/in_cos  sample strobe and samples
//                gain/enable/sat_clr     amplitude target, on/off, flag clear
//                data1/data2/out_valid   sine/cosine DAC words and update pulse
//                sat_flag/state_o        sticky saturation flag, FSM state
// ---------------------------------------------------------------------------
module dac_sample_conditioner
    import dac_pkg::*;
#(
    parameter int IN_W       = 16,
    parameter int OUT_W      = 14,
    parameter int GAIN_W     = 16,
    parameter int RAMP_STEP  = 64,
    parameter int OFFSET_BIN = 1
) (
    input logic                     sys_clk,
    input logic                     rst,
    dac_sample_conditioner_if.slave bus
);

    localparam logic [GAIN_W:0] STEP = (GAIN_W+1)'(RAMP_STEP);

    dac_state_t             state;
    logic      [GAIN_W-1:0] env;
    logic      [GAIN_W:0]   up_sum;
    logic      [GAIN_W-1:0] env_up;
    logic      [GAIN_W-1:0] env_down;

    logic signed [IN_W-1:0] s1_sin;
    logic signed [IN_W-1:0] s1_cos;
    logic                   s1_valid;
    logic                   s2_valid;
    logic                   out_valid_q;
    logic                   sat_flag_q;
    logic                   sat1;
    logic                   sat2;
    logic      [OUT_W-1:0]  data1_w;
    logic      [OUT_W-1:0]  data2_w;

    // Candidate envelope steps. The up step clamps at gain, which also covers
    // gain being lowered below env mid-ramp; the down step floors at zero.
    always_comb begin
        up_sum   = {1'b0, env} + STEP;
        env_up   = (up_sum >= {1'b0, bus.gain}) ? bus.gain : up_sum[GAIN_W-1:0];
        env_down = ({1'b0, env} > STEP) ? (env - STEP[GAIN_W-1:0]) : '0;
    end

    // Envelope FSM, advanced once per accepted sample. enable picks the
    // direction on that same sample, so a reversal continues from the
    // present env with no jump, and a fresh enable from IDLE reaches a gain
    // of N*RAMP_STEP after exactly N samples. env itself is the envelope in
    // effect for the sample captured in S1 on the same edge.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            env   <= '0;
        end else if (bus.in_valid) begin
            if (bus.enable) begin
                if (state == RUN) begin
                    env   <= bus.gain;
                    state <= RUN;
                end else begin
                    env   <= env_up;
                    state <= (env_up == bus.gain) ? RUN : RAMP_UP;
                end
            end else begin
                env   <= env_down;
                state <= (env_down == '0) ? IDLE : RAMP_DOWN;
            end
        end
    end

    // S1 sample capture and the valid shift register that paces S2/S3 and
    // produces out_valid three clocks after the strobe.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            s1_sin      <= '0;
            s1_cos      <= '0;
            s1_valid    <= 1'b0;
            s2_valid    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            s1_valid    <= bus.in_valid;
            s2_valid    <= s1_valid;
            out_valid_q <= s2_valid;
            if (bus.in_valid) begin
                s1_sin <= bus.in_sin;
                s1_cos <= bus.in_cos;
            end
        end
    end

    // Sticky saturation flag; a new saturation on the same edge as a clear
    // keeps the flag set so no event is lost.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            sat_flag_q <= 1'b0;
        end else if (s2_valid && (sat1 || sat2)) begin
            sat_flag_q <= 1'b1;
        end else if (bus.sat_clr) begin
            sat_flag_q <= 1'b0;
        end
    end

    dac_scale_sat #(
        .IN_W       (IN_W),
        .OUT_W      (OUT_W),
        .GAIN_W     (GAIN_W),
        .OFFSET_BIN (OFFSET_BIN)
    ) u_sin (
        .clk     (sys_clk),
        .rst     (rst),
        .s2_load (s1_valid),
        .s3_load (s2_valid),
        .sample  (s1_sin),
        .env     (env),
        .data    (data1_w),
        .sat     (sat1)
    );

    dac_scale_sat #(
        .IN_W       (IN_W),
        .OUT_W      (OUT_W),
        .GAIN_W     (GAIN_W),
        .OFFSET_BIN (OFFSET_BIN)
    ) u_cos (
        .clk     (sys_clk),
        .rst     (rst),
        .s2_load (s1_valid),
        .s3_load (s2_valid),
        .sample  (s1_cos),
        .env     (env),
        .data    (data2_w),
        .sat     (sat2)
    );

    assign bus.data1     = data1_w;
    assign bus.data2     = data2_w;
    assign bus.out_valid = out_valid_q;
    assign bus.sat_flag  = sat_flag_q;
    assign bus.state_o   = state;

endmodule

// File: tb/tb_dac_sample_conditioner.sv
// ---------------------------------------------------------------------------
// tb_dac_sample_conditioner
//   Self-checking bench for dac_sample_conditioner (OFFSET_BIN = 1).
//   A behavioural reference (envelope rules, integer arithmetic for the
//   scaling, a 3-deep delay line for latency) predicts every output on every
//   clock; a table of hand-computed vectors and a few directed sequences
//   cover the corner cases.
// ---------------------------------------------------------------------------
module tb_dac_sample_conditioner;
    import dac_pkg::*;

    localparam int IN_W   = 16;
    localparam int OUT_W  = 14;
    localparam int GAIN_W = 16;

    logic sys_clk = 1'b0;
    logic rst;

    always #5 sys_clk = ~sys_clk;

    dac_sample_conditioner_if #(.IN_W(IN_W), .OUT_W(OUT_W), .GAIN_W(GAIN_W)) intf ();

    dac_sample_conditioner #(
        .IN_W       (IN_W),
        .OUT_W      (OUT_W),
        .GAIN_W     (GAIN_W),
        .RAMP_STEP  (64),
        .OFFSET_BIN (1)
    ) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (intf.master)
    );

    int checks;
    int errors;

    // reference model state
    int m_env;
    int m_state;
    bit pv[3];
    int pd1[3];
    int pd2[3];
    bit ps[3];
    int exp_d1;
    int exp_d2;
    bit exp_ov;
    bit m_sat;

    typedef struct packed {
        int gain;
        int sin_v;
        int cos_v;
        int exp_d1;
        int exp_d2;
    } vec_t;

    vec_t vecs[8];

    // Offset-binary word for one sample: round half up of sample*env/2^17,
    // clipped to [-8192, 8191], then shifted up by midscale.
    function automatic int condWord(input int sample, input int env, output bit sat);
        longint p;
        longint r;
        p   = longint'(sample) * longint'(env);
        r   = (p + 64'sd65536) >>> 17;
        sat = (r > 8191) || (r < -8192);
        if (r > 8191)  r = 8191;
        if (r < -8192) r = -8192;
        return int'(r) + 8192;
    endfunction

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        compare("out_valid", 32'(intf.out_valid), 32'(exp_ov));
        compare("data1",     32'(intf.data1),     32'(exp_d1));
        compare("data2",     32'(intf.data2),     32'(exp_d2));
        compare("sat_flag",  32'(intf.sat_flag),  32'(m_sat));
        compare("state_o",   32'(intf.state_o),   32'(m_state));
    endtask

    task automatic applyStimulus(input bit valid, input int s, input int c, input int g,
                                 input bit en, input bit clr);
        intf.in_valid = valid;
        intf.in_sin   = 16'(s);
        intf.in_cos   = 16'(c);
        intf.gain     = 16'(g);
        intf.enable   = en;
        intf.sat_clr  = clr;
    endtask

    task automatic modelReset();
        m_env   = 0;
        m_state = 0;
        for (int i = 0; i < 3; i++) begin
            pv[i]  = 1'b0;
            pd1[i] = 0;
            pd2[i] = 0;
            ps[i]  = 1'b0;
        end
        exp_d1 = 'h2000;
        exp_d2 = 'h2000;
        exp_ov = 1'b0;
        m_sat  = 1'b0;
    endtask

    // One clock: capture the driven inputs, advance the reference by the
    // envelope rules and the 3-clock latency, then compare every output.
    task automatic tick();
        bit v;
        bit en;
        bit clr;
        bit sa;
        bit sb;
        int s;
        int c;
        int g;
        int w1;
        int w2;
        v   = intf.in_valid;
        s   = int'(intf.in_sin);
        c   = int'(intf.in_cos);
        g   = int'(intf.gain);
        en  = intf.enable;
        clr = intf.sat_clr;
        @(posedge sys_clk);
        #1;
        w1 = 0;
        w2 = 0;
        sa = 1'b0;
        sb = 1'b0;
        if (v) begin
            if (en) begin
                if (m_state == 2) m_env = g;
                else m_env = (m_env + 64 < g) ? m_env + 64 : g;
                m_state = (m_env == g) ? 2 : 1;
            end else begin
                m_env   = (m_env > 64) ? m_env - 64 : 0;
                m_state = (m_env == 0) ? 0 : 3;
            end
            w1 = condWord(s, m_env, sa);
            w2 = condWord(c, m_env, sb);
        end
        for (int i = 2; i > 0; i--) begin
            pv[i]  = pv[i-1];
            pd1[i] = pd1[i-1];
            pd2[i] = pd2[i-1];
            ps[i]  = ps[i-1];
        end
        pv[0]  = v;
        pd1[0] = w1;
        pd2[0] = w2;
        ps[0]  = sa | sb;
        exp_ov = pv[2];
        if (pv[2]) begin
            exp_d1 = pd1[2];
            exp_d2 = pd2[2];
        end
        if (pv[2] && ps[2]) m_sat = 1'b1;
        else if (clr)       m_sat = 1'b0;
        checkOutput();
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge sys_clk);
        #1;
        modelReset();
        checkOutput();
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog timeout at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        int prev;
        bit reached;
        bit en_r;
        int g_r;
        int s;
        int c;

        checks = 0;
        errors = 0;
        rst    = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0);

        vecs[0] = '{'h8000, 'h4000, 'hC000, 'h3000, 'h1000};
        vecs[1] = '{'hFFFF, 'h7FFF, 'h8000, 'h3FFF, 'h0000};
        vecs[2] = '{'h8000, 'h0000, 'h0000, 'h2000, 'h2000};
        vecs[3] = '{'h4000, 'h1000, 'hF000, 'h2200, 'h1E00};
        vecs[4] = '{'h8000, 'h0002, 'hFFFE, 'h2001, 'h2000};
        vecs[5] = '{'h8000, 'h0003, 'hFFFD, 'h2001, 'h1FFF};
        vecs[6] = '{'h8000, 'h7FFF, 'h8000, 'h3FFF, 'h0000};
        vecs[7] = '{'h0000, 'h1234, 'h8000, 'h2000, 'h2000};

        #2;
        doReset();

        // asynchronous reset in the middle of a ramp
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, 'h4000, 'hC000, 'h8000, 1, 0);
            tick();
        end
        rst = 1'b1;
        #1;
        compare("rst_async_data1",     32'(intf.data1),     32'h2000);
        compare("rst_async_data2",     32'(intf.data2),     32'h2000);
        compare("rst_async_out_valid", 32'(intf.out_valid), 32'h0);
        compare("rst_async_state",     32'(intf.state_o),   32'h0);
        compare("rst_async_sat",       32'(intf.sat_flag),  32'h0);
        #1;
        rst = 1'b0;
        modelReset();
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick();

        // ramp up from IDLE: RUN after exactly 512 samples, rising amplitude
        doReset();
        n       = 0;
        prev    = 0;
        reached = 1'b0;
        for (int i = 1; i <= 600 && !reached; i++) begin
            applyStimulus(1, 'h4000, 'hC000, 'h8000, 1, 0);
            tick();
            if (intf.out_valid) begin
                compare("ramp_monotonic", 32'(int'(intf.data1) >= prev), 32'h1);
                prev = int'(intf.data1);
            end
            if (intf.state_o == 2'd2) begin
                reached = 1'b1;
                n       = i;
            end
        end
        compare("ramp_len", 32'(n), 32'd512);

        // ramp reversal at 0x2000 and again at 0x1000
        doReset();
        for (int i = 0; i < 128; i++) begin
            applyStimulus(1, 'h4000, 'h0000, 'h8000, 1, 0);
            tick();
        end
        applyStimulus(1, 'h4000, 'h0000, 'h8000, 0, 0);
        tick();
        compare("reverse_down_state", 32'(intf.state_o), 32'd3);
        applyStimulus(0, 'h4000, 'h0000, 'h8000, 0, 0);
        tick();
        tick();
        compare("reverse_down_word", 32'(intf.data1), 32'h23F8);
        for (int i = 0; i < 63; i++) begin
            applyStimulus(1, 'h4000, 'h0000, 'h8000, 0, 0);
            tick();
        end
        applyStimulus(1, 'h4000, 'h0000, 'h8000, 1, 0);
        tick();
        compare("reverse_up_state", 32'(intf.state_o), 32'd1);
        applyStimulus(0, 'h4000, 'h0000, 'h8000, 1, 0);
        tick();
        tick();
        compare("reverse_up_word", 32'(intf.data1), 32'h2208);
        reached = 1'b0;
        for (int i = 0; i < 200 && !reached; i++) begin
            applyStimulus(1, 'h4000, 'h0000, 'h8000, 0, 0);
            tick();
            if (intf.state_o == 2'd0) reached = 1'b1;
        end
        compare("ramp_down_reaches_idle", 32'(reached), 32'h1);
        applyStimulus(0, 'h4000, 'h0000, 'h8000, 0, 0);
        repeat (3) tick();
        compare("idle_midscale", 32'(intf.data1), 32'h2000);

        // gain = 0 with enable: straight to RUN, then table of scaling vectors
        applyStimulus(1, 0, 0, 0, 1, 0);
        tick();
        compare("gain0_run", 32'(intf.state_o), 32'd2);
        foreach (vecs[k]) begin
            applyStimulus(1, vecs[k].sin_v, vecs[k].cos_v, vecs[k].gain, 1, 0);
            tick();
            applyStimulus(0, 0, 0, vecs[k].gain, 1, 0);
            tick();
            tick();
            compare($sformatf("vec%0d_data1", k), 32'(intf.data1), 32'(vecs[k].exp_d1));
            compare($sformatf("vec%0d_data2", k), 32'(intf.data2), 32'(vecs[k].exp_d2));
            compare($sformatf("vec%0d_valid", k), 32'(intf.out_valid), 32'h1);
            tick();
        end

        // saturation flag: clear, then set colliding with clear
        applyStimulus(0, 0, 0, 'hFFFF, 1, 1);
        tick();
        compare("sat_cleared", 32'(intf.sat_flag), 32'h0);
        applyStimulus(1, 'h7FFF, 0, 'hFFFF, 1, 0);
        tick();
        applyStimulus(0, 0, 0, 'hFFFF, 1, 0);
        tick();
        applyStimulus(0, 0, 0, 'hFFFF, 1, 1);
        tick();
        compare("sat_set_beats_clear", 32'(intf.sat_flag), 32'h1);
        compare("sat_word",            32'(intf.data1),    32'h3FFF);
        tick();
        compare("sat_clear_after",     32'(intf.sat_flag), 32'h0);

        // gain dropped below env during RAMP_UP clamps into RUN
        doReset();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 'h2000, 'hE000, 'h8000, 1, 0);
            tick();
        end
        applyStimulus(1, 'h2000, 'hE000, 'h0100, 1, 0);
        tick();
        compare("gain_drop_run", 32'(intf.state_o), 32'd2);

        // gapped strobes every 5th cycle from a fresh ramp
        doReset();
        for (int i = 0; i < 60; i++) begin
            applyStimulus((i % 5) == 0, $urandom_range(0, 'hFFFF), $urandom_range(0, 'hFFFF),
                          'h8000, 1, 0);
            tick();
        end
        compare("gapped_still_ramping", 32'(intf.state_o), 32'd1);

        // randomized traffic against the reference
        en_r = 1'b1;
        g_r  = 'h8000;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 149) == 0) en_r = ~en_r;
            if ($urandom_range(0, 199) == 0) begin
                case ($urandom_range(0, 3))
                    0:       g_r = 0;
                    1:       g_r = 'hFFFF;
                    2:       g_r = int'($urandom_range(0, 'hFFFF));
                    default: g_r = 'h8000;
                endcase
            end
            s = int'($urandom_range(0, 'hFFFF));
            c = int'($urandom_range(0, 'hFFFF));
            if ($urandom_range(0, 9) == 0) s = 'h7FFF;
            if ($urandom_range(0, 9) == 0) c = 'h8000;
            applyStimulus($urandom_range(0, 99) < 60, s, c, g_r, en_r,
                          $urandom_range(0, 19) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
